// File: rtl/line_addr_ctrl_pkg.sv
// Shared defaults and helpers for the median-filter line-address controller.
package line_addr_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_LINES  = 3;
    localparam int unsigned DEF_WIN    = 3;

    // Width of the completed-line counter for a ring of `lines` buffers.
    function automatic int unsigned lsw(input int unsigned lines);
        return (lines <= 2) ? 1 : $clog2(lines);
    endfunction

endpackage

// File: rtl/line_addr_ctrl_if.sv
// Video timing in, line-buffer addressing/select out.
interface line_addr_ctrl_if
    import line_addr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LINES  = DEF_LINES
);
    localparam int unsigned LSW = lsw(LINES);

    logic              vsync;
    logic              hsync;
    logic              pix_valid;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] width;
    logic [LINES-1:0]  wr_sel;
    logic [LSW-1:0]    line_cnt;
    logic              win_valid;
    logic              ovf;

    modport master (
        output vsync, hsync, pix_valid,
        input  addr, width, wr_sel, line_cnt, win_valid, ovf
    );

    modport slave (
        input  vsync, hsync, pix_valid,
        output addr, width, wr_sel, line_cnt, win_valid, ovf
    );

endinterface

// File: rtl/line_addr_ctrl_line_sel_ring.sv
// One-hot line-buffer write select rotator plus saturating completed-line counter.
module line_sel_ring
    import line_addr_ctrl_pkg::*;
#(
    parameter  int unsigned LINES = DEF_LINES,
    localparam int unsigned LSW   = lsw(LINES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [LINES-1:0] wr_sel,
    output logic [LSW-1:0]   line_cnt
);

    localparam logic [LSW-1:0]   CNT_MAX = LSW'(LINES - 1);
    localparam logic [LINES-1:0] SEL_0   = LINES'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel   <= SEL_0;
            line_cnt <= '0;
        end else if (clr) begin
            wr_sel   <= SEL_0;
            line_cnt <= '0;
        end else if (adv) begin
            wr_sel <= {wr_sel[LINES-2:0], wr_sel[LINES-1]};
            if (line_cnt != CNT_MAX)
                line_cnt <= line_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/line_addr_ctrl.sv
// Line-buffer address/width tracker with one-hot buffer rotation and window-ready flag.
module line_addr_ctrl
    import line_addr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned LINES  = DEF_LINES,
    parameter int unsigned WIN    = DEF_WIN
) (
    input  logic              clk,
    input  logic              rst,
    line_addr_ctrl_if.slave   bus
);

    localparam int unsigned       LSW      = lsw(LINES);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] COL_MIN  = ADDR_W'(WIN - 1);
    localparam logic [LSW-1:0]    ROW_MIN  = LSW'(WIN - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] width_q;
    logic              full_q;
    logic              ovf_q;
    logic              win_q;
    logic              win_hit;
    logic              adv;
    logic [LINES-1:0]  wr_sel;
    logic [LSW-1:0]    line_cnt;

    assign adv = bus.hsync && !bus.vsync;

    line_sel_ring #(.LINES(LINES)) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.vsync),
        .adv      (adv),
        .wr_sel   (wr_sel),
        .line_cnt (line_cnt)
    );

    always_comb begin
        win_hit = bus.pix_valid && !bus.hsync && !bus.vsync
                  && (line_cnt >= ROW_MIN) && (addr_q >= COL_MIN);
    end

    // addr doubles as the saturating pixel counter; full_q marks that the last
    // legal address has been consumed, so only the pixel after it overflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            width_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            win_q   <= 1'b0;
        end else if (bus.vsync) begin
            addr_q  <= '0;
            width_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            win_q   <= 1'b0;
        end else begin
            win_q <= win_hit;
            if (bus.hsync) begin
                width_q <= addr_q;
                addr_q  <= bus.pix_valid ? ADDR_W'(1) : '0;
                full_q  <= 1'b0;
            end else if (bus.pix_valid) begin
                if (full_q)
                    ovf_q <= 1'b1;
                else if (addr_q == ADDR_MAX)
                    full_q <= 1'b1;
                else
                    addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign bus.addr      = addr_q;
    assign bus.width     = width_q;
    assign bus.wr_sel    = wr_sel;
    assign bus.line_cnt  = line_cnt;
    assign bus.win_valid = win_q;
    assign bus.ovf       = ovf_q;

endmodule
